// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage. Owns the program counter, drives the
// variable-latency instruction bus (req/ack) and presents {pc, inst, valid}
// to the IF/ID register. Handles pipeline stall, branch redirect, exception
// flush and cancellation of an in-flight fetch.
//
// Optional build macro: FETCH_BUF_EN adds a one-entry fetch buffer and the
// HOLD state, so a fetch that completes under stall is kept, not refetched.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   stall[5:0]                  pipeline stall vector (bit 0 = PC stage)
//   flush, new_pc               exception flush and its target
//   branch_flag_i               taken branch/jump from ID
//   branch_target_addr_i        branch/jump target
//   ibus_ack_i, ibus_rdata_i    bus ack and read data (same cycle)
//   ibus_req_o, ibus_addr_o     bus request (level) and address
//   if_pc, if_inst, if_rom_ce   presented pc / instruction / valid
//   stallreq_if                 fetch not complete, stall the pipe
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_rom_ce,
  output logic        stallreq_if
);

`ifdef FETCH_BUF_EN
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_DISCARD, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_DISCARD} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redirect, redirect_nxt;
  logic        outstanding;

  // Only the PC-stage stall bit matters here.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

`ifdef FETCH_BUF_EN
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      pc       <= RESET_PC;
      redirect <= '0;
`ifdef FETCH_BUF_EN
      buf_pc   <= '0;
      buf_inst <= '0;
`endif
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redirect <= redirect_nxt;
`ifdef FETCH_BUF_EN
      buf_pc   <= buf_pc_nxt;
      buf_inst <= buf_inst_nxt;
`endif
    end
  end

  assign outstanding = (state == S_FETCH) || (state == S_DISCARD);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    redirect_nxt = redirect;
`ifdef FETCH_BUF_EN
    buf_pc_nxt   = buf_pc;
    buf_inst_nxt = buf_inst;
`endif
    if (flush) begin
      // A request still on the bus must be allowed to finish before the
      // new target can be issued; park the target until the late ack.
      if (outstanding && !ibus_ack_i) begin
        redirect_nxt = new_pc;
        state_nxt    = S_DISCARD;
      end else begin
        pc_nxt    = new_pc;
        state_nxt = S_FETCH;
      end
    end else begin
      case (state)
        S_RESET: state_nxt = S_FETCH;
        S_FETCH: begin
          if (ibus_ack_i && !stall[0]) begin
            pc_nxt = branch_flag_i ? branch_target_addr_i : pc + 32'd4;
          end else if (!ibus_ack_i && branch_flag_i && !stall[0]) begin
            redirect_nxt = branch_target_addr_i;
            state_nxt    = S_DISCARD;
          end
`ifdef FETCH_BUF_EN
          else if (ibus_ack_i && stall[0]) begin
            buf_pc_nxt   = pc;
            buf_inst_nxt = ibus_rdata_i;
            state_nxt    = S_HOLD;
          end
`endif
        end
        S_DISCARD: begin
          if (ibus_ack_i) begin
            pc_nxt    = redirect;
            state_nxt = S_FETCH;
          end
        end
`ifdef FETCH_BUF_EN
        S_HOLD: begin
          if (!stall[0]) begin
            pc_nxt    = branch_flag_i ? branch_target_addr_i : buf_pc + 32'd4;
            state_nxt = S_FETCH;
          end
        end
`endif
        default: state_nxt = S_RESET;
      endcase
    end
  end

  always_comb begin
    ibus_req_o  = 1'b0;
    ibus_addr_o = '0;
    if_pc       = '0;
    if_inst     = '0;
    if_rom_ce   = 1'b0;
    stallreq_if = 1'b0;
    case (state)
      S_FETCH: begin
        ibus_req_o  = 1'b1;
        ibus_addr_o = pc;
        if_pc       = pc;
        if (ibus_ack_i) begin
          if_inst   = ibus_rdata_i;
          if_rom_ce = 1'b1;
        end else begin
          stallreq_if = 1'b1;
        end
      end
      S_DISCARD: begin
        ibus_req_o  = 1'b1;
        ibus_addr_o = pc;
        stallreq_if = 1'b1;
      end
`ifdef FETCH_BUF_EN
      S_HOLD: begin
        if_pc     = buf_pc;
        if_inst   = buf_inst;
        if_rom_ce = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
